// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter sharing one single-ported memory between fetch and data ports
//
// Purpose:
//   Serialises instruction-fetch (IF) and load/store (D) requests onto one
//   memory through a registered req/ack handshake.  The data port wins ties
//   unless it has already been granted STARVE_LIMIT times in a row while a
//   fetch was waiting, in which case the fetch is forced through.
//
// Optional build macro:
//   MEM_TIMEOUT_EN - aborts a transfer after TIMEOUT_CYCLES busy cycles with
//                    no mem_ack, returns 32'hDEAD_BEEF and sets sticky err.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   if_req/if_addr              fetch request and address
//   if_rdata/if_ready           fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata   data request, write enable, address, store data
//   d_rdata/d_ready             load data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata   request to the memory, held until mem_ack
//   mem_rdata/mem_ack           memory read data and single-cycle completion
//   busy                        high in every state except IDLE
//   err                         sticky timeout flag (tied 0 without MEM_TIMEOUT_EN)

module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  state_t     nextState;
  logic       grantD;
  logic       grantI;
  logic       inBusy;
  logic       timedOut;
  logic       finish;
  logic [3:0] streak;

  logic [DATA_W-1:0] returnData;

  assign inBusy = (state == BUSY_I) || (state == BUSY_D);
  // A transfer ends either on the memory's ack or on the optional timeout.
  assign finish = inBusy && (mem_ack || timedOut);
  assign returnData = timedOut ? DATA_W'(32'hDEAD_BEEF) : mem_rdata;
  assign busy = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] toCnt;

  // toCnt counts completed busy cycles, so the abort lands on the
  // TIMEOUT_CYCLES-th busy cycle.
  assign timedOut = inBusy && !mem_ack && (toCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      toCnt <= '0;
      err   <= 1'b0;
    end else begin
      if (grantD || grantI) begin
        toCnt <= '0;
      end else if (inBusy && !mem_ack) begin
        toCnt <= toCnt + 1'b1;
      end
      if (timedOut) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign timedOut      = 1'b0;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    grantD    = 1'b0;
    grantI    = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless the fetch side has been passed over STARVE_LIMIT times.
        if (d_req && (!if_req || (streak < 4'(STARVE_LIMIT)))) begin
          grantD    = 1'b1;
          nextState = BUSY_D;
        end else if (if_req) begin
          grantI    = 1'b1;
          nextState = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      streak    <= '0;
    end else begin
      // Ready is only ever high for the single DONE cycle.
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (grantD) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (!if_req) begin
          streak <= '0;
        end else if (streak != 4'(STARVE_LIMIT)) begin
          streak <= streak + 1'b1;
        end
      end else if (grantI) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        streak    <= '0;
      end

      if (finish) begin
        mem_req <= 1'b0;
        if (state == BUSY_I) begin
          if_rdata <= returnData;
          if_ready <= 1'b1;
        end else begin
          // Stores leave d_rdata alone; an aborted store still reports the marker.
          if (!mem_we || timedOut) begin
            d_rdata <= returnData;
          end
          d_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(3),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant, checks the address, acks after ackWait cycles and
  // checks the ready pulse, leaving the arbiter in IDLE.
  task automatic serve(input string tag, input logic expD, input logic [31:0] expAddr,
                       input int ackWait, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk({tag, "_grant_timeout"}, 64'(mem_req), 64'd1);
    chk({tag, "_addr"}, 64'(mem_addr), 64'(expAddr));
    repeat (ackWait) tick();
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack   = 1'b0;
    chk({tag, "_rdy"}, {62'd0, d_ready, if_ready}, expD ? 64'd2 : 64'd1);
    tick();
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_outs", {mem_req, mem_we, if_ready, d_ready, busy, err}, 64'd0);
    chk("rst_data", 64'(mem_addr | mem_wdata | if_rdata | d_rdata), 64'd0);
    reset = 1'b0;
    tick();

    // IF only, zero-wait memory
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("if_memreq", {mem_req, mem_we, busy}, 64'b101);
    chk("if_memaddr", 64'(mem_addr), 64'h40);
    chk("if_early_rdy", 64'(if_ready), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    chk("if_rdy", {if_ready, d_ready, mem_req}, 64'b100);
    chk("if_rdata", 64'(if_rdata), 64'h8C01_0004);
    tick();
    chk("if_rdy_drop", {if_ready, busy}, 64'd0);

    // Store with three wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st_hold%0d", i), {mem_req, mem_we, d_ready}, 64'b110);
      chk($sformatf("st_fields%0d", i), {mem_addr, mem_wdata}, {32'h100, 32'h1234_5678});
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
      end
      tick();
    end
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk("st_rdy", {d_ready, if_ready, mem_req}, 64'b100);
    chk("st_rdata_kept", 64'(d_rdata), 64'd0);
    tick();

    // Load updates d_rdata
    d_req = 1'b1; d_addr = 32'h104;
    serve("ld", 1'b1, 32'h104, 0, 32'hCAFE_0001);
    d_req = 1'b0;
    chk("ld_rdata", 64'(d_rdata), 64'hCAFE_0001);
    chk("ld_ifrdata_kept", 64'(if_rdata), 64'h8C01_0004);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack", {busy, if_ready, d_ready, mem_req}, 64'd0);

    // Simultaneous requests: D first, then I
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_addr = 32'h200;
    tick();
    chk("sim_first_d", {mem_req, 32'(mem_addr)}, {1'b1, 32'h200});
    d_req = 1'b0;
    serve("sim_d", 1'b1, 32'h200, 1, 32'h11);
    serve("sim_i", 1'b0, 32'h80, 0, 32'h22);
    if_req = 1'b0;
    chk("sim_if_rdata", 64'(if_rdata), 64'h22);

    // Starvation: D,D,D,I,D with both requests held
    reset = 1'b1; tick(); reset = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    serve("sv1_d", 1'b1, 32'h200, 0, 32'h1);
    serve("sv2_d", 1'b1, 32'h200, 0, 32'h2);
    serve("sv3_d", 1'b1, 32'h200, 0, 32'h3);
    chk("sv_streak3", 64'(dut.streak), 64'd3);
    serve("sv4_i", 1'b0, 32'h80, 0, 32'h4);
    chk("sv_streak0", 64'(dut.streak), 64'd0);
    serve("sv5_d", 1'b1, 32'h200, 0, 32'h5);
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Reset in the middle of a data transfer
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300;
    tick();
    chk("rmid_busy", {mem_req, busy}, 64'b11);
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    tick();
    reset = 1'b0;
    chk("rmid_drop", {mem_req, busy, d_ready}, 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rmid_norpy", {d_ready, if_ready}, 64'd0);
    if_req = 1'b1; if_addr = 32'h44;
    serve("rmid_if", 1'b0, 32'h44, 0, 32'h0BAD_F00D);
    if_req = 1'b0;
    chk("rmid_if_rdata", 64'(if_rdata), 64'h0BAD_F00D);

`ifdef MEM_TIMEOUT_EN
    // Timeout: no ack for four busy cycles
    d_req = 1'b1; d_addr = 32'h400;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), {mem_req, d_ready, err}, 64'b100);
    end
    tick();
    d_req = 1'b0;
    chk("to_rdy", {d_ready, mem_req, err}, 64'b101);
    chk("to_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
    tick(); tick(); tick();
    chk("to_sticky", {err, busy}, 64'b10);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("to_rst_clr", 64'(err), 64'd0);
`else
    chk("err_tied", 64'(err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
